// File: rtl/qspi_resp_pkg.sv
// Shared types and constants for the QSPI flash responder.
package qspi_resp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StData,
        StIgnore
    } resp_state_e;

    localparam logic [7:0]  CMD_QUAD_READ        = 8'h6B;
    localparam int unsigned DEFAULT_DUMMY_CYCLES = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI line, with single-cycle rise/fall pulses
// derived from the synchronized level.
module spi_sync_edge #(
    parameter bit ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
            prev_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/qspi_flash_responder.sv
// Quad Output Fast Read target: decodes command/address on IO0, serves memory bytes as nibbles.
// Define QSPI_RESP_CMD_CHECK_EN to reject opcodes other than CMD_READ (frame ignored until CS_n).
module qspi_flash_responder
    import qspi_resp_pkg::*;
#(
    parameter int unsigned ADDR_W       = 24,
    parameter int unsigned DUMMY_CYCLES = DEFAULT_DUMMY_CYCLES,
    parameter logic [7:0]  CMD_READ     = CMD_QUAD_READ
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_clk_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_mosi_i,
    output logic [3:0]        spi_d_o,
    output logic [3:0]        spi_d_oe_o,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_data_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam logic [4:0]        CmdLast   = 5'd7;
    localparam logic [4:0]        AddrLast  = 5'(ADDR_W - 1);
    localparam logic [4:0]        DummyLast = 5'(DUMMY_CYCLES - 1);
    localparam logic [ADDR_W-1:0] AddrOne   = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic sck_lvl, sck_rise, sck_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge #(.ResetVal(1'b0)) u_sync_sck (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (spi_clk_i),
        .q_o    (sck_lvl),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    spi_sync_edge #(.ResetVal(1'b1)) u_sync_cs (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (spi_cs_n_i),
        .q_o    (cs_s),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_sync_edge #(.ResetVal(1'b0)) u_sync_mosi (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (spi_mosi_i),
        .q_o    (mosi_s),
        .rise_o (mosi_rise),
        .fall_o (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sck_lvl, cs_rise, mosi_rise, mosi_fall};

    resp_state_e       state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        pf_q, pf_d;
    logic              pf_vld_q, pf_vld_d;
    logic [3:0]        lo_q, lo_d;
    logic [3:0]        nib_q, nib_d;
    logic              half_q, half_d;
    logic              oe_q, oe_d;
    logic              err_q, err_d;
    logic              rd_dly_q, rd_dly_d;

    // Opcode bits share the address shift register; they are shifted out by the address bits.
    logic cmd_match, cmd_ok;
    assign cmd_match = ({addr_q[6:0], mosi_s} == CMD_READ);
`ifdef QSPI_RESP_CMD_CHECK_EN
    assign cmd_ok = cmd_match;
`else
    logic unused_cmd_match;
    assign unused_cmd_match = cmd_match;
    assign cmd_ok           = 1'b1;
`endif

    logic data_fall, frame_start;
    assign data_fall   = (state_q == StData) && sck_fall && !cs_s;
    assign frame_start = (state_q == StIdle) && cs_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cs_fall) state_d = StCmd;
            StCmd:    if (sck_rise && cnt_q == CmdLast) state_d = cmd_ok ? StAddr : StIgnore;
            StAddr:   if (sck_rise && cnt_q == AddrLast) state_d = StDummy;
            StDummy:  if (sck_rise && cnt_q == DummyLast) state_d = StData;
            StData:   state_d = StData;
            StIgnore: state_d = StIgnore;
            default:  state_d = StIdle;
        endcase
        if (cs_s) state_d = StIdle;
    end

    always_comb begin
        busy_o   = (state_q != StIdle);
        mem_rd_o = !cs_s && (((state_q == StDummy) && sck_rise && (cnt_q == DummyLast))
                             || (data_fall && half_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            addr_q   <= '0;
            pf_q     <= '0;
            pf_vld_q <= 1'b0;
            lo_q     <= '0;
            nib_q    <= '0;
            half_q   <= 1'b0;
            oe_q     <= 1'b0;
            err_q    <= 1'b0;
            rd_dly_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            pf_q     <= pf_d;
            pf_vld_q <= pf_vld_d;
            lo_q     <= lo_d;
            nib_q    <= nib_d;
            half_q   <= half_d;
            oe_q     <= oe_d;
            err_q    <= err_d;
            rd_dly_q <= rd_dly_d;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        pf_d     = pf_q;
        pf_vld_d = pf_vld_q;
        lo_d     = lo_q;
        nib_d    = nib_q;
        half_d   = half_q;
        oe_d     = oe_q;
        err_d    = err_q;
        rd_dly_d = mem_rd_o;

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (sck_rise && (state_q inside {StCmd, StAddr, StDummy})) begin
            cnt_d = cnt_q + 5'd1;
        end

        if (sck_rise && !cs_s && (state_q inside {StCmd, StAddr})) begin
            addr_d = {addr_q[ADDR_W-2:0], mosi_s};
        end
        if (mem_rd_o) addr_d = addr_q + AddrOne;

        if (data_fall) begin
            oe_d = 1'b1;
            if (!half_q) begin
                // High nibble needs a whole byte; a missing prefetch is an underrun.
                if (pf_vld_q) begin
                    nib_d = pf_q[7:4];
                    lo_d  = pf_q[3:0];
                end else begin
                    nib_d = 4'h0;
                    lo_d  = 4'h0;
                    err_d = 1'b1;
                end
                pf_vld_d = 1'b0;
                half_d   = 1'b1;
            end else begin
                nib_d  = lo_q;
                half_d = 1'b0;
            end
        end

        if (rd_dly_q) begin
            pf_d     = mem_data_i;
            pf_vld_d = 1'b1;
        end

        if (cs_s) begin
            oe_d   = 1'b0;
            half_d = 1'b0;
        end

        if (frame_start) begin
            err_d    = 1'b0;
            pf_vld_d = 1'b0;
            half_d   = 1'b0;
            nib_d    = 4'h0;
        end
    end

    assign spi_d_o    = nib_q;
    assign spi_d_oe_o = {4{oe_q}};
    assign mem_addr_o = addr_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Scoreboard bench: a master model drives QSPI frames; monitors check read addresses and nibbles.
module tb_qspi_flash_responder;

    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic [3:0]  d, oe;
    logic        mem_rd;
    logic [23:0] mem_addr;
    logic [7:0]  mem_data = 8'h00;
    logic        busy, err;

    always #5 clk = ~clk;

    qspi_flash_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_clk_i  (sck),
        .spi_cs_n_i (cs_n),
        .spi_mosi_i (mosi),
        .spi_d_o    (d),
        .spi_d_oe_o (oe),
        .mem_rd_o   (mem_rd),
        .mem_addr_o (mem_addr),
        .mem_data_i (mem_data),
        .busy_o     (busy),
        .err_o      (err)
    );

    logic [7:0] mem [int unsigned];

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[7:0] ^ a[15:8] ^ 8'h96;
    endfunction

    always @(posedge clk) if (mem_rd) mem_data <= mem_byte(mem_addr);

    int checks = 0;
    int passed = 0;
    logic [3:0]  exp_nib[$];
    logic [23:0] exp_rd[$];
    bit chk_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    always @(posedge sck) begin
        if (chk_en && !cs_n && oe == 4'hF) begin
            if (exp_nib.size() == 0) begin
                checks++;
                $display("FAIL nib_extra: got %h, expected none", d);
            end else begin
                check("nibble", {28'h0, d}, {28'h0, exp_nib.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && mem_rd) begin
            if (exp_rd.size() == 0) begin
                checks++;
                $display("FAIL rd_extra: got %h, expected none", mem_addr);
            end else begin
                check("rd_addr", {8'h0, mem_addr}, {8'h0, exp_rd.pop_front()});
            end
        end
    end

    task automatic sck_bit(input logic b, input int half);
        @(negedge clk);
        mosi = b;
        repeat (half - 1) @(negedge clk);
        sck = 1'b1;
        repeat (half) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic start_frame(input logic [7:0] op, input logic [23:0] a, input int half);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 7; i >= 0; i--) sck_bit(op[i], half);
        for (int i = 23; i >= 0; i--) sck_bit(a[i], half);
        repeat (8) sck_bit(1'b0, half);
    endtask

    task automatic data_bytes(input int n, input int half);
        for (int i = 0; i < 2 * n; i++) begin
            repeat (half) @(negedge clk);
            sck = 1'b1;
            repeat (half) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic end_frame();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic do_read(input logic [7:0] op, input logic [23:0] a, input int n);
        logic [23:0] x;
        logic [7:0]  b;
        for (int i = 0; i <= n; i++) begin
            x = a + 24'(i);
            exp_rd.push_back(x);
            if (i < n) begin
                b = mem_byte(x);
                exp_nib.push_back(b[7:4]);
                exp_nib.push_back(b[3:0]);
            end
        end
        start_frame(op, a, HALF);
        data_bytes(n, HALF);
        end_frame();
        check("busy_end", {31'h0, busy}, 32'h0);
        check("oe_end", {28'h0, oe}, 32'h0);
        check("err_end", {31'h0, err}, 32'h0);
        check("nib_left", exp_nib.size(), 32'h0);
        check("rd_left", exp_rd.size(), 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        mem[32'h10] = 8'hA5;
        mem[32'h11] = 8'h3C;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_d", {28'h0, d}, 32'h0);
        check("rst_oe", {28'h0, oe}, 32'h0);
        check("rst_rd", {31'h0, mem_rd}, 32'h0);
        check("rst_addr", {8'h0, mem_addr}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic read: A5, 3C
        do_read(8'h6B, 24'h000010, 2);

        // Reset in the middle of the data phase
        chk_en = 1'b0;
        start_frame(8'h6B, 24'h000100, HALF);
        data_bytes(1, HALF);
        check("mid_busy", {31'h0, busy}, 32'h1);
        check("mid_oe", {28'h0, oe}, 32'hF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mr_d", {28'h0, d}, 32'h0);
        check("mr_oe", {28'h0, oe}, 32'h0);
        check("mr_rd", {31'h0, mem_rd}, 32'h0);
        check("mr_addr", {8'h0, mem_addr}, 32'h0);
        check("mr_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cs_n  = 1'b1;
        sck   = 1'b0;
        repeat (6) @(negedge clk);
        exp_nib.delete();
        exp_rd.delete();
        chk_en = 1'b1;
        do_read(8'h6B, 24'h000010, 2);

        // Address wrap
        do_read(8'h6B, 24'hFFFFFF, 4);

        // Abort after 12 address bits
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 7; i >= 0; i--) sck_bit(1'(8'h6B >> i), HALF);
        for (int i = 23; i >= 12; i--) sck_bit(1'(24'h123456 >> i), HALF);
        check("ab_busy_pre", {31'h0, busy}, 32'h1);
        @(negedge clk);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("ab_busy", {31'h0, busy}, 32'h0);
        check("ab_oe", {28'h0, oe}, 32'h0);
        repeat (4) @(negedge clk);
        do_read(8'h6B, 24'h000ABC, 2);

        // Foreign opcode
`ifdef QSPI_RESP_CMD_CHECK_EN
        start_frame(8'h03, 24'h000020, HALF);
        data_bytes(2, HALF);
        check("ign_oe", {28'h0, oe}, 32'h0);
        check("ign_busy", {31'h0, busy}, 32'h1);
        end_frame();
        check("ign_busy_end", {31'h0, busy}, 32'h0);
`else
        do_read(8'h03, 24'h000020, 2);
`endif

        // SCK at clk/2 underruns; err is sticky until the next CS_n fall
        chk_en = 1'b0;
        start_frame(8'h6B, 24'h000040, 1);
        data_bytes(2, 1);
        repeat (4) @(negedge clk);
        check("ur_err", {31'h0, err}, 32'h1);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check("ur_err_sticky", {31'h0, err}, 32'h1);
        chk_en = 1'b1;
        cs_n = 1'b0;
        repeat (5) @(negedge clk);
        check("ur_err_clr", {31'h0, err}, 32'h0);
        check("hold_busy", {31'h0, busy}, 32'h1);
        check("hold_oe", {28'h0, oe}, 32'h0);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        do_read(8'h6B, 24'h000200, 3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
